// File: rtl/orange_lut_eval_if.sv
// Stream bundle for orange_lut_eval: the serial truth-table load, the evaluation
// input and the registered result.
interface orange_lut_eval_if #(
    parameter int N_IN = 5
);
    logic            cfg_valid;
    logic            cfg_ready;
    logic            cfg_bit;
    logic            in_valid;
    logic            in_ready;
    logic [N_IN-1:0] in_vec;
    logic            out_valid;
    logic            out_ready;
    logic            y;

    modport master (
        output cfg_valid, cfg_bit, in_valid, in_vec, out_ready,
        input  cfg_ready, in_ready, out_valid, y
    );

    modport slave (
        input  cfg_valid, cfg_bit, in_valid, in_vec, out_ready,
        output cfg_ready, in_ready, out_valid, y
    );
endinterface

// File: rtl/orange_lut_eval.sv
// Programmable N_IN-input Boolean function: a serially loaded truth table,
// a one-deep registered evaluation stream and an on-set counting sweep.
//
// state | meaning
// IDLE  | evaluations accepted; waits for cfg_start / sweep_start
// LOAD  | shifting cfg_bit into the shadow table, minterm 0 first
// SWEEP | walking minterms 0..TT_W-1 and summing the active table
module orange_lut_eval #(
    parameter int                   N_IN       = 5,
    parameter logic [(1<<N_IN)-1:0] DEFAULT_TT = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_start,
    input  logic             sweep_start,
    output logic             sweep_busy,
    output logic             sweep_done,
    output logic [N_IN:0]    minterm_cnt,
    orange_lut_eval_if.slave bus
);
    localparam int TT_W = 1 << N_IN;
    localparam int CW   = N_IN + 1;

    typedef enum logic [1:0] {IDLE, LOAD, SWEEP} state_t;

    state_t          state, state_nxt;
    logic [N_IN-1:0] idx;
    logic [TT_W-1:0] shadow, shadow_wr, active;
    logic [CW-1:0]   acc, acc_sum;
    logic            cfg_fire, in_fire, idx_last;

    assign cfg_fire = bus.cfg_valid & bus.cfg_ready;
    assign in_fire  = bus.in_valid & bus.in_ready;
    assign idx_last = &idx;
    assign acc_sum  = acc + CW'(active[idx]);

    // The last bit goes straight into the active table together with the rest.
    always_comb begin
        shadow_wr      = shadow;
        shadow_wr[idx] = bus.cfg_bit;
    end

    always_comb begin
        state_nxt     = state;
        bus.cfg_ready = 1'b0;
        bus.in_ready  = 1'b0;
        sweep_busy    = 1'b0;
        unique case (state)
            IDLE: begin
                bus.in_ready = ~bus.out_valid | bus.out_ready;
                if (cfg_start)
                    state_nxt = LOAD;
                else if (sweep_start)
                    state_nxt = SWEEP;
            end
            LOAD: begin
                bus.cfg_ready = 1'b1;
                if (cfg_fire && idx_last)
                    state_nxt = IDLE;
            end
            SWEEP: begin
                sweep_busy = 1'b1;
                if (idx_last)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx           <= '0;
            shadow        <= '0;
            active        <= DEFAULT_TT;
            acc           <= '0;
            minterm_cnt   <= '0;
            sweep_done    <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.y         <= 1'b0;
        end else begin
            sweep_done <= 1'b0;

            if (state == LOAD && cfg_fire) begin
                shadow <= shadow_wr;
                if (idx_last) begin
                    active <= shadow_wr;
                    idx    <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end

            if (state == SWEEP) begin
                if (idx_last) begin
                    minterm_cnt <= acc_sum;
                    sweep_done  <= 1'b1;
                    acc         <= '0;
                    idx         <= '0;
                end else begin
                    acc <= acc_sum;
                    idx <= idx + 1'b1;
                end
            end

            if (in_fire) begin
                bus.out_valid <= 1'b1;
                bus.y         <= active[bus.in_vec];
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_orange_lut_eval.sv
// Self-checking bench for orange_lut_eval: truth-table model, stream scoreboard
// and on-set counts derived from the loaded table.
module tb_orange_lut_eval;
    localparam int N    = 5;
    localparam int TT_W = 1 << N;

    logic        clk = 1'b0;
    logic        reset, cfg_start, sweep_start;
    logic        sweep_busy, sweep_done;
    logic [N:0]  minterm_cnt;
    int          total = 0;
    int          bad   = 0;
    logic [TT_W-1:0] model_tt;

    orange_lut_eval_if #(.N_IN(N)) bus ();

    orange_lut_eval #(.N_IN(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_start  (cfg_start),
        .sweep_start(sweep_start),
        .sweep_busy (sweep_busy),
        .sweep_done (sweep_done),
        .minterm_cnt(minterm_cnt),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic eval_one(input logic [N-1:0] v, input string name);
        logic expv;
        expv          = model_tt[v];
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_vec    = v;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL %s_in_ready: got %b want 1", name, bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        total++;
        if (bus.out_valid !== 1'b1 || bus.y !== expv) begin
            bad++; $display("FAIL %s: got valid=%b y=%b want valid=1 y=%b", name, bus.out_valid, bus.y, expv);
        end
        tick();
    endtask

    task automatic start_load(input logic with_sweep);
        cfg_start   = 1'b1;
        sweep_start = with_sweep;
        tick();
        cfg_start   = 1'b0;
        sweep_start = 1'b0;
    endtask

    task automatic feed_bits(input logic [TT_W-1:0] tt, input bit stalls, input int sweep_at, input string name);
        int k   = 0;
        int cyc = 0;
        while (k < TT_W && cyc < 400) begin
            bus.cfg_valid = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.cfg_bit   = tt[k];
            sweep_start   = (k == sweep_at);
            #1;
            if (bus.cfg_valid && bus.cfg_ready) k++;
            tick();
            cyc++;
        end
        bus.cfg_valid = 1'b0;
        sweep_start   = 1'b0;
        model_tt      = tt;
        total++;
        if (k != TT_W) begin
            bad++; $display("FAIL %s_bits: got %0d want %0d", name, k, TT_W);
        end
        if (!stalls) begin
            total++;
            if (cyc != TT_W) begin
                bad++; $display("FAIL %s_cycles: got %0d want %0d", name, cyc, TT_W);
            end
        end
        total++;
        if (bus.cfg_ready !== 1'b0) begin
            bad++; $display("FAIL %s_exit: got cfg_ready=%b want 0", name, bus.cfg_ready);
        end
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        cfg_start     = 1'b0;
        sweep_start   = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_bit   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_vec    = '0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        total++;
        if (bus.out_valid !== 1'b0 || bus.y !== 1'b0 || bus.cfg_ready !== 1'b0) begin
            bad++; $display("FAIL reset_stream: got valid=%b y=%b cfg_ready=%b want 0 0 0", bus.out_valid, bus.y, bus.cfg_ready);
        end
        total++;
        if (sweep_busy !== 1'b0 || sweep_done !== 1'b0 || minterm_cnt !== '0) begin
            bad++; $display("FAIL reset_sweep: got busy=%b done=%b cnt=%0d want 0 0 0", sweep_busy, sweep_done, minterm_cnt);
        end
        reset    = 1'b0;
        model_tt = '0;
    endtask

    task automatic test_default_eval();
        eval_one(5'd0,  "default_0");
        eval_one(5'd13, "default_13");
        eval_one(5'd31, "default_31");
        total++;
        if (minterm_cnt !== '0) begin
            bad++; $display("FAIL default_cnt: got %0d want 0", minterm_cnt);
        end
    endtask

    task automatic test_load();
        logic old_y;
        old_y         = model_tt[31];
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_vec    = 5'd31;
        cfg_start     = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL load_start_accept: got %b want 1", bus.in_ready);
        end
        tick();
        cfg_start    = 1'b0;
        bus.in_valid = 1'b0;
        feed_bits(32'h8000_0001, 1'b0, -1, "load_sparse");
        total++;
        if (bus.out_valid !== 1'b1 || bus.y !== old_y) begin
            bad++; $display("FAIL load_pending: got valid=%b y=%b want valid=1 y=%b", bus.out_valid, bus.y, old_y);
        end
        bus.out_ready = 1'b1;
        tick();
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL load_drain: got %b want 0", bus.out_valid);
        end
        eval_one(5'd0,  "sparse_0");
        eval_one(5'd31, "sparse_31");
        eval_one(5'd7,  "sparse_7");
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_vec    = 5'd0;
        tick();
        total++;
        if (bus.out_valid !== 1'b1 || bus.y !== model_tt[0]) begin
            bad++; $display("FAIL bp_first: got valid=%b y=%b want 1 %b", bus.out_valid, bus.y, model_tt[0]);
        end
        bus.in_vec = 5'd7;
        #1;
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL bp_stall_ready: got %b want 0", bus.in_ready);
        end
        tick();
        total++;
        if (bus.out_valid !== 1'b1 || bus.y !== model_tt[0]) begin
            bad++; $display("FAIL bp_hold: got valid=%b y=%b want 1 %b", bus.out_valid, bus.y, model_tt[0]);
        end
        bus.out_ready = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        total++;
        if (bus.out_valid !== 1'b1 || bus.y !== model_tt[7]) begin
            bad++; $display("FAIL bp_second: got valid=%b y=%b want 1 %b", bus.out_valid, bus.y, model_tt[7]);
        end
        tick();
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL bp_empty: got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_sweep(input string name);
        int busy  = 0;
        int guard = 0;
        int expc;
        expc        = $countones(model_tt);
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        while (sweep_busy === 1'b1 && guard < 200) begin
            busy++;
            if (sweep_done !== 1'b0 || bus.in_ready !== 1'b0) begin
                total++; bad++;
                $display("FAIL %s_busy_flags: got done=%b in_ready=%b want 0 0", name, sweep_done, bus.in_ready);
            end
            tick();
            guard++;
        end
        total++;
        if (busy != TT_W) begin
            bad++; $display("FAIL %s_busy_cycles: got %0d want %0d", name, busy, TT_W);
        end
        total++;
        if (sweep_done !== 1'b1 || minterm_cnt !== expc[N:0]) begin
            bad++; $display("FAIL %s_result: got done=%b cnt=%0d want done=1 cnt=%0d", name, sweep_done, minterm_cnt, expc);
        end
        tick();
        total++;
        if (sweep_done !== 1'b0 || minterm_cnt !== expc[N:0]) begin
            bad++; $display("FAIL %s_hold: got done=%b cnt=%0d want done=0 cnt=%0d", name, sweep_done, minterm_cnt, expc);
        end
    endtask

    task automatic test_reset_mid_load();
        start_load(1'b0);
        for (int i = 0; i < 10; i++) begin
            bus.cfg_valid = 1'b1;
            bus.cfg_bit   = 1'b1;
            tick();
        end
        bus.cfg_valid = 1'b0;
        reset         = 1'b1;
        tick();
        reset    = 1'b0;
        model_tt = '0;
        total++;
        if (bus.cfg_ready !== 1'b0 || minterm_cnt !== '0 || sweep_done !== 1'b0) begin
            bad++; $display("FAIL midload_reset: got cfg_ready=%b cnt=%0d done=%b want 0 0 0", bus.cfg_ready, minterm_cnt, sweep_done);
        end
        eval_one(5'd31, "midload_31");
        eval_one(5'd0,  "midload_0");
    endtask

    task automatic test_reset_mid_sweep();
        start_load(1'b0);
        feed_bits('1, 1'b0, -1, "load_ones2");
        test_sweep("sweep_ones2");
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        model_tt = '0;
        total++;
        if (sweep_busy !== 1'b0 || minterm_cnt !== '0 || sweep_done !== 1'b0) begin
            bad++; $display("FAIL midsweep_reset: got busy=%b cnt=%0d done=%b want 0 0 0", sweep_busy, minterm_cnt, sweep_done);
        end
        tick();
        total++;
        if (sweep_busy !== 1'b0 || sweep_done !== 1'b0) begin
            bad++; $display("FAIL midsweep_after: got busy=%b done=%b want 0 0", sweep_busy, sweep_done);
        end
    endtask

    task automatic test_start_priority();
        logic [TT_W-1:0] tt;
        tt = TT_W'($urandom);
        start_load(1'b1);
        total++;
        if (bus.cfg_ready !== 1'b1 || sweep_busy !== 1'b0) begin
            bad++; $display("FAIL prio_both: got cfg_ready=%b busy=%b want 1 0", bus.cfg_ready, sweep_busy);
        end
        feed_bits(tt, 1'b0, 5, "prio_load");
        tick();
        total++;
        if (sweep_busy !== 1'b0 || sweep_done !== 1'b0) begin
            bad++; $display("FAIL prio_no_queue: got busy=%b done=%b want 0 0", sweep_busy, sweep_done);
        end
        eval_one(5'd5,  "prio_5");
        eval_one(5'd18, "prio_18");
    endtask

    task automatic test_back_to_back(input int n, input bit full, input string name);
        logic         mov, my, exp_rdy;
        logic [N-1:0] v;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        mov = 1'b0;
        my  = 1'b0;
        for (int i = 0; i < n; i++) begin
            v             = N'($urandom);
            bus.in_vec    = v;
            bus.in_valid  = full ? 1'b1 : 1'($urandom_range(0, 1));
            bus.out_ready = full ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = !mov || bus.out_ready;
            total++;
            if (bus.in_ready !== exp_rdy) begin
                bad++; $display("FAIL %s_ready[%0d]: got %b want %b", name, i, bus.in_ready, exp_rdy);
            end
            if (bus.in_valid && exp_rdy) begin
                mov = 1'b1;
                my  = model_tt[v];
            end else if (bus.out_ready) begin
                mov = 1'b0;
            end
            tick();
            total++;
            if (bus.out_valid !== mov || (mov && bus.y !== my)) begin
                bad++; $display("FAIL %s_out[%0d]: got valid=%b y=%b want valid=%b y=%b", name, i, bus.out_valid, bus.y, mov, my);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_default_eval();
        test_load();
        test_backpressure();
        test_sweep("sweep_sparse");
        start_load(1'b0);
        feed_bits('1, 1'b1, -1, "load_ones");
        test_sweep("sweep_ones");
        test_reset_mid_load();
        test_reset_mid_sweep();
        test_start_priority();
        start_load(1'b0);
        feed_bits(TT_W'($urandom), 1'b1, -1, "load_rand");
        test_sweep("sweep_rand");
        test_back_to_back(16, 1'b1, "b2b_full");
        test_back_to_back(300, 1'b0, "b2b_rand");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
